uart_byte_rx_cfg: RTL and testbench

- Serial-to-parallel UART byte receiver.
- Counterpart to the team's configurable UART byte transmitter; uses the same runtime baud divisor and bits/parity/stop configuration encodings.
- Sits between the external RX pin and the USB-CDC bridge / protocol debugger capture path.
- Delivers one byte per frame with a done pulse and per-frame parity and framing error flags.

---
 rtl/uart_byte_rx_cfg.sv | 152 +++++++++++++++
 tb/tb_uart_byte_rx_cfg.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx_cfg.sv
// UART byte receiver with runtime baud divisor and per-frame bits/parity/stop configuration.
// Delivers one byte per frame with a done pulse plus parity and framing error flags.
module uart_byte_rx_cfg #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    input  logic [15:0] baud_divisor,
    input  logic [3:0]  bits_cfg,
    input  logic [1:0]  parity_cfg,
    input  logic [1:0]  stop_cfg,
    output logic [7:0]  data_byte,
    output logic        rx_done,
    output logic        parity_err,
    output logic        frame_err,
    output logic        rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_IDLE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync;
    logic        rx_s;
    logic        rx_prev;
    logic [15:0] cnt;
    logic [15:0] limit;
    logic        tick;
    logic        start_edge;
    logic        finish;
    logic        stop_bad;
    logic [3:0]  bits_dec;
    logic [3:0]  n_bits;
    logic        par_en;
    logic        par_odd;
    logic        two_stop;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_bit;
    logic        ferr;

    assign rx_s       = sync[SYNC_STAGES-1];
    assign bits_dec   = (bits_cfg >= 4'd5 && bits_cfg <= 4'd8) ? bits_cfg : 4'd8;
    assign limit      = (state == START) ? {1'b0, baud_divisor[15:1]} : baud_divisor;
    assign tick       = (state != IDLE) && (cnt == limit - 16'd1);
    assign start_edge = (state == IDLE) && rx_prev && !rx_s;
    assign stop_bad   = ferr | ~rx_s;

    // Synchronizer presets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start_edge) state_next = START;
            START:     if (tick) state_next = rx_s ? IDLE : DATA;
            DATA:      if (tick && {1'b0, bit_idx} == n_bits - 4'd1)
                           state_next = par_en ? PARITY : STOP1;
            PARITY:    if (tick) state_next = STOP1;
            STOP1:     if (tick) begin
                           if (two_stop)      state_next = STOP2;
                           else if (stop_bad) state_next = WAIT_IDLE;
                           else               state_next = IDLE;
                       end
            STOP2:     if (tick) state_next = stop_bad ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        finish  = tick && ((state == STOP1 && !two_stop) || state == STOP2);
        rx_busy = (state != IDLE) && (state != WAIT_IDLE);
    end

    // Frame configuration is latched at the start edge; only baud_divisor is used live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            n_bits     <= 4'd8;
            par_en     <= 1'b0;
            par_odd    <= 1'b0;
            two_stop   <= 1'b0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr       <= 1'b0;
            data_byte  <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done <= finish;
            if (start_edge) begin
                cnt      <= '0;
                n_bits   <= bits_dec;
                par_en   <= (parity_cfg == 2'b01) || (parity_cfg == 2'b10);
                par_odd  <= (parity_cfg == 2'b10);
                two_stop <= (stop_cfg == 2'd2);
                bit_idx  <= '0;
                shreg    <= '0;
                par_bit  <= 1'b0;
                ferr     <= 1'b0;
            end else if (state != IDLE) begin
                cnt <= tick ? '0 : cnt + 16'd1;
                if (tick) begin
                    case (state)
                        DATA: begin
                            shreg[bit_idx] <= rx_s;
                            bit_idx        <= bit_idx + 3'd1;
                        end
                        PARITY:       par_bit <= rx_s;
                        STOP1, STOP2: if (!rx_s) ferr <= 1'b1;
                        default:      ;
                    endcase
                end
            end
            // Unused upper data bits stay zero, so parity over shreg covers only the N bits.
            if (finish) begin
                data_byte  <= shreg;
                parity_err <= par_en & (^shreg ^ par_bit ^ par_odd);
                frame_err  <= stop_bad;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx_cfg.sv
// Testbench for uart_byte_rx_cfg: frames are built from a bit-level wire model and
// every rx_done is checked against expected data, flags and arrival cycle.
module tb_uart_byte_rx_cfg;

    localparam int SYNC = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       busy;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] baud_divisor = 16'd16;
    logic [3:0]  bits_cfg = 4'd8;
    logic [1:0]  parity_cfg = 2'd0;
    logic [1:0]  stop_cfg = 2'd1;
    logic [7:0]  data_byte;
    logic        rx_done;
    logic        parity_err;
    logic        frame_err;
    logic        rx_busy;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   busy_seen = 0;
    rec_t mon_rec;
    rec_t last_rec = '0;
    rec_t done_q[$];
    int   done_cyc_q[$];
    rec_t exp_q[$];
    int   exp_cyc_q[$];

    uart_byte_rx_cfg #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rx(uart_rx),
        .baud_divisor(baud_divisor),
        .bits_cfg(bits_cfg),
        .parity_cfg(parity_cfg),
        .stop_cfg(stop_cfg),
        .data_byte(data_byte),
        .rx_done(rx_done),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            mon_rec.data = data_byte;
            mon_rec.perr = parity_err;
            mon_rec.ferr = frame_err;
            mon_rec.busy = rx_busy;
            done_q.push_back(mon_rec);
            done_cyc_q.push_back(cyc);
        end
        if (rx_busy) busy_seen = 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_queues();
        done_q.delete();
        done_cyc_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    // Must be entered just after a rising edge; drives a whole frame from the wire model.
    task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit low_last_stop,
                              input bit scramble);
        int n, p, s, bd, start_cyc;
        logic [7:0] mask;
        logic pbit;
        logic wire_q[$];
        rec_t r;
        n = (bits_cfg >= 5 && bits_cfg <= 8) ? int'(bits_cfg) : 8;
        p = (parity_cfg == 2'd1) ? 1 : (parity_cfg == 2'd2) ? 2 : 0;
        s = (stop_cfg == 2'd2) ? 2 : 1;
        bd = int'(baud_divisor);
        mask = 8'((1 << n) - 1);
        wire_q.push_back(1'b0);
        for (int i = 0; i < n; i++) wire_q.push_back(d[i]);
        if (p != 0) begin
            pbit = ($countones(d & mask) % 2) != 0;
            if (p == 2) pbit = ~pbit;
            if (flip_par) pbit = ~pbit;
            wire_q.push_back(pbit);
        end
        for (int k = 0; k < s; k++) wire_q.push_back(!(low_last_stop && k == s - 1));
        r.data = d & mask;
        r.perr = flip_par && (p != 0);
        r.ferr = low_last_stop;
        r.busy = 1'b0;
        last_rec = r;
        start_cyc = cyc;
        exp_q.push_back(r);
        exp_cyc_q.push_back(start_cyc + SYNC + bd / 2 + (n + (p != 0 ? 1 : 0) + s) * bd + 1);
        for (int i = 0; i < wire_q.size(); i++) begin
            uart_rx = wire_q[i];
            if (scramble && i == 1) begin
                bits_cfg   = 4'($urandom_range(0, 15));
                parity_cfg = 2'($urandom_range(0, 3));
                stop_cfg   = 2'($urandom_range(0, 3));
            end
            repeat (bd) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({data_byte, rx_done, parity_err, frame_err, rx_busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_hold: got data=%02h done=%b pe=%b fe=%b busy=%b, expected all 0",
                     data_byte, rx_done, parity_err, frame_err, rx_busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({data_byte, rx_done, parity_err, frame_err, rx_busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_release: got data=%02h done=%b pe=%b fe=%b busy=%b, expected all 0",
                     data_byte, rx_done, parity_err, frame_err, rx_busy);
        end
    endtask

    task automatic test_8n1();
        clear_queues();
        baud_divisor = 16; bits_cfg = 8; parity_cfg = 0; stop_cfg = 1;
        @(posedge clk); #1;
        send_frame(8'hA5, 0, 0, 0);
        repeat (20) @(posedge clk); #1;
        vectors++;
        if (done_q.size() != 1) begin
            miscompares++;
            $display("FAIL 8n1_count: got %0d rx_done pulses, expected 1", done_q.size());
        end
        vectors++;
        if (done_q.size() < 1 || done_q[0] !== exp_q[0] || done_cyc_q[0] != exp_cyc_q[0]) begin
            miscompares++;
            $display("FAIL 8n1_frame: got rec=%03h cyc=%0d, expected rec=%03h cyc=%0d",
                     done_q.size() ? done_q[0] : 11'h0, done_cyc_q.size() ? done_cyc_q[0] : -1,
                     exp_q[0], exp_cyc_q[0]);
        end
    endtask

    task automatic test_parity_7e1();
        clear_queues();
        baud_divisor = 16; bits_cfg = 7; parity_cfg = 1; stop_cfg = 1;
        @(posedge clk); #1;
        send_frame(8'h5A, 0, 0, 0);
        send_frame(8'h5A, 1, 0, 0);
        repeat (20) @(posedge clk); #1;
        vectors++;
        if (done_q.size() != 2) begin
            miscompares++;
            $display("FAIL 7e1_count: got %0d rx_done pulses, expected 2", done_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= done_q.size() || done_q[i] !== exp_q[i] || done_cyc_q[i] != exp_cyc_q[i]) begin
                miscompares++;
                $display("FAIL 7e1_frame%0d: got rec=%03h cyc=%0d, expected rec=%03h cyc=%0d", i,
                         i < done_q.size() ? done_q[i] : 11'h0,
                         i < done_cyc_q.size() ? done_cyc_q[i] : -1, exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_5o2_break();
        clear_queues();
        baud_divisor = 16; bits_cfg = 5; parity_cfg = 2; stop_cfg = 2;
        @(posedge clk); #1;
        send_frame(8'h13, 0, 1, 0);
        repeat (3 * 16) @(posedge clk); #1;
        vectors++;
        if (done_q.size() != 1 || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL 5o2_break_hold: got %0d pulses busy=%b, expected 1 pulse busy=0",
                     done_q.size(), rx_busy);
        end
        uart_rx = 1'b1;
        repeat (16) @(posedge clk); #1;
        send_frame(8'h0F, 0, 0, 0);
        repeat (20) @(posedge clk); #1;
        vectors++;
        if (done_q.size() != 2) begin
            miscompares++;
            $display("FAIL 5o2_count: got %0d rx_done pulses, expected 2", done_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= done_q.size() || done_q[i] !== exp_q[i] || done_cyc_q[i] != exp_cyc_q[i]) begin
                miscompares++;
                $display("FAIL 5o2_frame%0d: got rec=%03h cyc=%0d, expected rec=%03h cyc=%0d", i,
                         i < done_q.size() ? done_q[i] : 11'h0,
                         i < done_cyc_q.size() ? done_cyc_q[i] : -1, exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_glitch();
        clear_queues();
        baud_divisor = 32; bits_cfg = 8; parity_cfg = 0; stop_cfg = 1;
        @(posedge clk); #1;
        busy_seen = 1'b0;
        uart_rx = 1'b0;
        repeat (8) @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (64) @(posedge clk); #1;
        vectors++;
        if (busy_seen !== 1'b1 || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_busy: got seen=%b now=%b, expected seen=1 now=0", busy_seen, rx_busy);
        end
        vectors++;
        if (done_q.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_done: got %0d rx_done pulses, expected 0", done_q.size());
        end
        vectors++;
        if ({data_byte, parity_err, frame_err} !== {last_rec.data, last_rec.perr, last_rec.ferr}) begin
            miscompares++;
            $display("FAIL glitch_hold: got data=%02h pe=%b fe=%b, expected data=%02h pe=%b fe=%b",
                     data_byte, parity_err, frame_err, last_rec.data, last_rec.perr, last_rec.ferr);
        end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        baud_divisor = 16; bits_cfg = 8; parity_cfg = 0; stop_cfg = 1;
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (16 * 3) @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (16) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({data_byte, rx_done, parity_err, frame_err, rx_busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL midreset_outputs: got data=%02h done=%b pe=%b fe=%b busy=%b, expected all 0",
                     data_byte, rx_done, parity_err, frame_err, rx_busy);
        end
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk); #1;
        vectors++;
        if (done_q.size() != 0 || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_stale: got %0d pulses busy=%b, expected 0 pulses busy=0",
                     done_q.size(), rx_busy);
        end
        send_frame(8'h3C, 0, 0, 0);
        repeat (20) @(posedge clk); #1;
        vectors++;
        if (done_q.size() != 1 || done_q[0] !== exp_q[0] || done_cyc_q[0] != exp_cyc_q[0]) begin
            miscompares++;
            $display("FAIL midreset_frame: got %0d pulses rec=%03h, expected 1 pulse rec=%03h",
                     done_q.size(), done_q.size() ? done_q[0] : 11'h0, exp_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        baud_divisor = 4; bits_cfg = 8; parity_cfg = 0; stop_cfg = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) send_frame(8'(i), 0, 0, 0);
        repeat (20) @(posedge clk); #1;
        vectors++;
        if (done_q.size() != 10) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d rx_done pulses, expected 10", done_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= done_q.size() || done_q[i] !== exp_q[i] || done_cyc_q[i] != exp_cyc_q[i]) begin
                miscompares++;
                $display("FAIL b2b_frame%0d: got rec=%03h cyc=%0d, expected rec=%03h cyc=%0d", i,
                         i < done_q.size() ? done_q[i] : 11'h0,
                         i < done_cyc_q.size() ? done_cyc_q[i] : -1, exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_queues();
        @(posedge clk); #1;
        for (int f = 0; f < 12; f++) begin
            baud_divisor = 16'($urandom_range(4, 24));
            bits_cfg     = 4'($urandom_range(0, 15));
            parity_cfg   = 2'($urandom_range(0, 3));
            stop_cfg     = 2'($urandom_range(0, 3));
            send_frame(8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 1'b1);
            uart_rx = 1'b1;
            repeat (int'(baud_divisor) + 4) @(posedge clk); #1;
        end
        vectors++;
        if (done_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count: got %0d rx_done pulses, expected %0d", done_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= done_q.size() || done_q[i] !== exp_q[i] || done_cyc_q[i] != exp_cyc_q[i]) begin
                miscompares++;
                $display("FAIL random_frame%0d: got rec=%03h cyc=%0d, expected rec=%03h cyc=%0d", i,
                         i < done_q.size() ? done_q[i] : 11'h0,
                         i < done_cyc_q.size() ? done_cyc_q[i] : -1, exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_7e1();
        test_5o2_break();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
